// File: rtl/mlp_frame_driver.sv
// mlp_frame_driver
//   Host-side driver for the emotion MLP core. Collects a stream of signed int8
//   features into an N_FEAT-wide frame and fires it at the MLP with a one-cycle
//   valid pulse. The frame is held stable while the MLP works. The three class
//   scores are then captured and reduced to an argmax result. That result is
//   returned on a valid/ready handshake.
//
// Ports
//   clk, reset                  clock (rising edge), asynchronous active-low reset
//   s_data/s_valid/s_last       feature byte stream in; s_ready is the accept signal
//   x_flat                      frame to the MLP, feature k at bits [8k+7:8k]
//   mlp_valid_in                one-cycle frame pulse to the MLP
//   mlp_valid_out, y0..y2       MLP result valid and signed class scores
//   m_class/m_score/m_valid     argmax result out; m_ready is the consumer accept
//   err_frame, err_timeout      one-cycle error pulses
//
// Optional feature: define MLP_DRIVER_STATS_EN to add the frames_ok and errors
// event counters (16 bit, wrapping, cleared on reset).

module mlp_frame_driver #(
    parameter int unsigned N_FEAT  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [8*N_FEAT-1:0] x_flat,
    output logic                mlp_valid_in,
    input  logic                mlp_valid_out,
    input  logic [15:0]         y0,
    input  logic [15:0]         y1,
    input  logic [15:0]         y2,
    output logic [1:0]          m_class,
    output logic [15:0]         m_score,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                err_frame,
    output logic                err_timeout
`ifdef MLP_DRIVER_STATS_EN
    ,
    output logic [15:0]         frames_ok,
    output logic [15:0]         errors
`endif
);

    localparam int unsigned CW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntLast = CW'(N_FEAT - 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StLoad,
        StDrain,
        StFire,
        StWait,
        StOut
    } state_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [TW-1:0]      tmo;

    // Argmax of the live MLP scores; strict compares keep the lowest index on ties.
    logic [1:0]         best_class;
    logic signed [15:0] best_score;

    always_comb begin
        best_class = 2'd0;
        best_score = $signed(y0);
        if ($signed(y1) > best_score) begin
            best_class = 2'd1;
            best_score = $signed(y1);
        end
        if ($signed(y2) > best_score) begin
            best_class = 2'd2;
            best_score = $signed(y2);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StLoad;
            cnt          <= '0;
            tmo          <= '0;
            s_ready      <= 1'b0;
            x_flat       <= '0;
            mlp_valid_in <= 1'b0;
            m_class      <= 2'd0;
            m_score      <= 16'd0;
            m_valid      <= 1'b0;
            err_frame    <= 1'b0;
            err_timeout  <= 1'b0;
`ifdef MLP_DRIVER_STATS_EN
            frames_ok    <= 16'd0;
            errors       <= 16'd0;
`endif
        end else begin
            mlp_valid_in <= 1'b0;
            err_frame    <= 1'b0;
            err_timeout  <= 1'b0;

            unique case (state)
                StLoad: begin
                    // s_ready comes up here on the first edge after reset release.
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        x_flat[8*cnt +: 8] <= s_data;
                        if (s_last) begin
                            cnt <= '0;
                            if (cnt == CntLast) begin
                                state        <= StFire;
                                s_ready      <= 1'b0;
                                mlp_valid_in <= 1'b1;
                                // tmo counts cycles since the pulse, FIRE included.
                                tmo          <= '0;
                            end else begin
                                err_frame <= 1'b1;
`ifdef MLP_DRIVER_STATS_EN
                                errors    <= errors + 16'd1;
`endif
                            end
                        end else if (cnt == CntLast) begin
                            // Frame overran without s_last: drop the rest of it.
                            cnt       <= '0;
                            err_frame <= 1'b1;
                            state     <= StDrain;
`ifdef MLP_DRIVER_STATS_EN
                            errors    <= errors + 16'd1;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                StDrain: begin
                    if (s_valid && s_ready && s_last) begin
                        state <= StLoad;
                    end
                end

                StFire: begin
                    tmo   <= tmo + 1'b1;
                    state <= StWait;
                end

                StWait: begin
                    if (mlp_valid_out) begin
                        m_class <= best_class;
                        m_score <= best_score;
                        m_valid <= 1'b1;
                        state   <= StOut;
                    end else if (tmo == TmoLast) begin
                        err_timeout <= 1'b1;
                        s_ready     <= 1'b1;
                        state       <= StLoad;
`ifdef MLP_DRIVER_STATS_EN
                        errors      <= errors + 16'd1;
`endif
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                StOut: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= StLoad;
`ifdef MLP_DRIVER_STATS_EN
                        frames_ok <= frames_ok + 16'd1;
`endif
                    end
                end

                default: begin
                    state   <= StLoad;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
